// File: rtl/approx_mul_pkg.sv
// Shared widths and types for the approximate-multiplier error accumulator.
// s2_t is sized from OP_W_DEF, so the operand width is changed here rather
// than by overriding OP_W on an instance.
package approx_mul_pkg;

    localparam int OP_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 48;
    localparam int PROD_W    = 2 * OP_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Payload leaving S2: signed error, its magnitude, its square, nonzero flag.
    typedef struct packed {
        logic signed [PROD_W:0] err;
        logic [PROD_W-1:0]      abs_err;
        logic [2*PROD_W-1:0]    sq;
        logic                   nz;
    } s2_t;

endpackage

// File: rtl/approx_mul_err_acc_if.sv
// Sample stream from the approximate multiplier into the error accumulator.
interface approx_mul_err_acc_if #(
    parameter int OP_W = approx_mul_pkg::OP_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [2*OP_W-1:0] approx_prod;

    modport master (output in_valid, op_a, op_b, approx_prod, input in_ready);
    modport slave  (input in_valid, op_a, op_b, approx_prod, output in_ready);
endinterface

// File: rtl/approx_err_pipe.sv
// S1/S2 of the error pipeline: exact product and signed error in S1,
// magnitude, square and nonzero flag in S2. No flow control; every
// accepted sample moves one stage per clock.
module approx_err_pipe
    import approx_mul_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_fire,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [2*OP_W-1:0] approx_prod,
    output logic              s2_valid,
    output s2_t               s2,
    output logic              busy
);

    localparam int PW = 2 * OP_W;

    logic [PW-1:0]      exact;
    logic signed [PW:0] err_c;
    logic               s1_valid;
    logic signed [PW:0] s1_err;
    s2_t                s2_next;

    assign exact = op_a * op_b;
    // One extra bit keeps approx - exact exact over the full +/-(2^PW - 1) range.
    assign err_c = {1'b0, approx_prod} - {1'b0, exact};
    assign busy  = s1_valid | s2_valid;

    // S2 payload derived from the registered S1 error.
    always_comb begin
        logic [PW-1:0] neg_err;
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        s2_next         = '0;
        neg_err         = PW'(-s1_err);
        s2_next.err     = s1_err;
        s2_next.abs_err = s1_err[PW] ? neg_err : s1_err[PW-1:0];
        s2_next.sq      = s2_next.abs_err * s2_next.abs_err;
        s2_next.nz      = (s1_err != '0);
    end

    // Valid bits shift with the data and are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            s2_valid <= s1_valid;
        end
    end

    // Payload registers load only together with their stage's valid bit.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; nothing reads them unless the matching valid bit is set.
        if (in_fire)  s1_err <= err_c;
        if (s1_valid) s2     <= s2_next;
    end

endmodule

// File: rtl/approx_mul_err_acc.sv
// Streaming error-metric accumulator behind the 8x8 approximate multiplier.
// Runs a programmed number of samples through a 3-stage pipeline and
// accumulates signed, absolute and squared error, max |error| and the
// count of erroneous samples. Results are final while done is high.
module approx_mul_err_acc
    import approx_mul_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    approx_mul_err_acc_if.slave  s_if,
    output logic [ACC_W-1:0]     sum_err,
    output logic [ACC_W-1:0]     sum_abs_err,
    output logic [ACC_W-1:0]     sum_sq_err,
    output logic [2*OP_W-1:0]    max_abs_err,
    output logic [CNT_W-1:0]     err_count,
    output logic                 done
);

    localparam int PW = 2 * OP_W;

    state_e           state;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             start_ok;
    logic             pipe_busy;
    logic             s2_valid;
    logic             s3_valid;
    s2_t              s2;
    s2_t              s3;

    assign s_if.in_ready = (state == ST_RUN);
    assign done          = (state == ST_DONE);
    assign accept        = s_if.in_valid & s_if.in_ready;
    assign start_ok      = start & ((state == ST_IDLE) | (state == ST_DONE));

    approx_err_pipe #(
        .OP_W (OP_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_fire     (accept),
        .op_a        (s_if.op_a),
        .op_b        (s_if.op_b),
        .approx_prod (s_if.approx_prod),
        .s2_valid    (s2_valid),
        .s2          (s2),
        .busy        (pipe_busy)
    );

    // Run control: start, sample countdown, drain of in-flight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        remaining <= num_samples;
                        state     <= (num_samples == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!(pipe_busy | s3_valid)) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // S3 valid bit; reset drops any sample still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3_valid <= 1'b0;
        else        s3_valid <= s2_valid;
    end

    // S3 payload register feeding the accumulators.
    always_ff @(posedge clk) begin
        if (s2_valid) s3 <= s2;
    end

    // Accumulators: cleared on reset and on an accepted start, updated from S3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
        end else if (start_ok) begin
            sum_err     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
        end else if (s3_valid) begin
            sum_err     <= sum_err + {{(ACC_W-PW-1){s3.err[PW]}}, s3.err};
            sum_abs_err <= sum_abs_err + {{(ACC_W-PW){1'b0}}, s3.abs_err};
            sum_sq_err  <= sum_sq_err + {{(ACC_W-2*PW){1'b0}}, s3.sq};
            if (s3.abs_err > max_abs_err) max_abs_err <= s3.abs_err;
            err_count   <= err_count + {{(CNT_W-1){1'b0}}, s3.nz};
        end
    end

endmodule

// File: tb/tb_approx_mul_err_acc.sv
// Directed bench for approx_mul_err_acc: table of complete runs plus
// hand-written sequences for abort-by-reset, zero-length runs, DONE
// behaviour and gapped input with an ignored mid-run start.
module tb_approx_mul_err_acc;

    typedef struct packed {
        logic [15:0]       n;
        logic [3:0][7:0]   a;
        logic [3:0][7:0]   b;
        logic [3:0][15:0]  p;
        logic [47:0]       e_sum;
        logic [47:0]       e_abs;
        logic [47:0]       e_sq;
        logic [15:0]       e_max;
        logic [15:0]       e_cnt;
    } run_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic [47:0] sum_err;
    logic [47:0] sum_abs_err;
    logic [47:0] sum_sq_err;
    logic [15:0] max_abs_err;
    logic [15:0] err_count;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    run_t        runs [4];
    logic [7:0]  tog_a [4];
    logic [7:0]  tog_b [4];
    logic [15:0] tog_p [4];

    approx_mul_err_acc_if s_if ();

    approx_mul_err_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .s_if        (s_if),
        .sum_err     (sum_err),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .max_abs_err (max_abs_err),
        .err_count   (err_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [47:0] e_sum, input logic [47:0] e_abs,
                                 input logic [47:0] e_sq, input logic [15:0] e_max, input logic [15:0] e_cnt);
        check({tag, " sum_err"},     64'(sum_err),     64'(e_sum));
        check({tag, " sum_abs_err"}, 64'(sum_abs_err), 64'(e_abs));
        check({tag, " sum_sq_err"},  64'(sum_sq_err),  64'(e_sq));
        check({tag, " max_abs_err"}, 64'(max_abs_err), 64'(e_max));
        check({tag, " err_count"},   64'(err_count),   64'(e_cnt));
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input string tag, input logic [15:0] n);
        start       = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
        if (n == 16'd0) begin
            check({tag, " done"}, 64'(done), 64'd1);
        end else begin
            check({tag, " in_ready"}, 64'(s_if.in_ready), 64'd1);
            check({tag, " done"},     64'(done),          64'd0);
        end
        check_results({tag, " cleared"}, 48'd0, 48'd0, 48'd0, 16'd0, 16'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic feed_one(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int k = 0;
        s_if.in_valid    = 1'b1;
        s_if.op_a        = a;
        s_if.op_b        = b;
        s_if.approx_prod = p;
        while (s_if.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed timeout: in_ready=%b, expected 1", s_if.in_ready);
        end
        @(negedge clk);
        s_if.in_valid = 1'b0;
    endtask

    // Called at the negedge after the last accept; counts cycles until done.
    task automatic wait_done(input string tag, input logic [47:0] e_sq);
        int c = 0;
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 3) check({tag, " sum_sq_err at t+3"}, 64'(sum_sq_err), 64'(e_sq));
        end
        check({tag, " done latency"}, 64'(c), 64'd4);
    endtask

    initial begin
        runs[0] = '0;
        runs[0].n = 16'd3;
        runs[0].a[0] = 8'd3;   runs[0].b[0] = 8'd5;   runs[0].p[0] = 16'd15;
        runs[0].a[1] = 8'd255; runs[0].b[1] = 8'd255; runs[0].p[1] = 16'd65024;
        runs[0].a[2] = 8'd0;   runs[0].b[2] = 8'd7;   runs[0].p[2] = 16'd0;
        runs[0].e_sum = -48'sd1; runs[0].e_abs = 48'd1; runs[0].e_sq = 48'd1;
        runs[0].e_max = 16'd1;   runs[0].e_cnt = 16'd1;

        runs[1] = '0;
        runs[1].n = 16'd2;
        runs[1].a[0] = 8'd16;  runs[1].b[0] = 8'd16;  runs[1].p[0] = 16'd260;
        runs[1].a[1] = 8'd10;  runs[1].b[1] = 8'd10;  runs[1].p[1] = 16'd90;
        runs[1].e_sum = -48'sd6; runs[1].e_abs = 48'd14; runs[1].e_sq = 48'd116;
        runs[1].e_max = 16'd10;  runs[1].e_cnt = 16'd2;

        // Extreme errors: -65025 and +65535.
        runs[2] = '0;
        runs[2].n = 16'd2;
        runs[2].a[0] = 8'd255; runs[2].b[0] = 8'd255; runs[2].p[0] = 16'd0;
        runs[2].a[1] = 8'd0;   runs[2].b[1] = 8'd0;   runs[2].p[1] = 16'd65535;
        runs[2].e_sum = 48'd510; runs[2].e_abs = 48'd130560; runs[2].e_sq = 48'd8523086850;
        runs[2].e_max = 16'd65535; runs[2].e_cnt = 16'd2;

        runs[3] = '0;
        runs[3].n = 16'd1;
        runs[3].a[0] = 8'd1;   runs[3].b[0] = 8'd1;   runs[3].p[0] = 16'd3;
        runs[3].e_sum = 48'd2; runs[3].e_abs = 48'd2; runs[3].e_sq = 48'd4;
        runs[3].e_max = 16'd2; runs[3].e_cnt = 16'd1;

        tog_a = '{8'd16, 8'd10, 8'd1, 8'd2};
        tog_b = '{8'd16, 8'd10, 8'd1, 8'd3};
        tog_p = '{16'd260, 16'd90, 16'd3, 16'd6};

        rst_n            = 1'b0;
        start            = 1'b0;
        num_samples      = 16'd0;
        s_if.in_valid    = 1'b0;
        s_if.op_a        = 8'd0;
        s_if.op_b        = 8'd0;
        s_if.approx_prod = 16'd0;

        #12;
        check_results("reset", 48'd0, 48'd0, 48'd0, 16'd0, 16'd0);
        check("reset in_ready", 64'(s_if.in_ready), 64'd0);
        check("reset done",     64'(done),          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a 5-sample run after 2 samples.
        do_start("abort", 16'd5);
        feed_one(8'd16, 8'd16, 16'd260);
        feed_one(8'd16, 8'd16, 16'd260);
        repeat (3) @(negedge clk);
        check("abort partial sum_abs_err", 64'(sum_abs_err), 64'd8);
        rst_n = 1'b0;
        #1;
        check_results("abort", 48'd0, 48'd0, 48'd0, 16'd0, 16'd0);
        check("abort in_ready", 64'(s_if.in_ready), 64'd0);
        check("abort done",     64'(done),          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s_if.in_valid    = 1'b1;
        s_if.op_a        = 8'd16;
        s_if.op_b        = 8'd16;
        s_if.approx_prod = 16'd260;
        repeat (5) @(negedge clk);
        check("idle in_ready",    64'(s_if.in_ready), 64'd0);
        check("idle done",        64'(done),          64'd0);
        check("idle sum_abs_err", 64'(sum_abs_err),   64'd0);
        s_if.in_valid = 1'b0;

        // Complete runs, back-to-back samples.
        for (int r = 0; r < 4; r++) begin
            string tag;
            tag = $sformatf("run%0d", r);
            do_start(tag, runs[r].n);
            for (int i = 0; i < int'(runs[r].n); i++)
                feed_one(runs[r].a[i], runs[r].b[i], runs[r].p[i]);
            check({tag, " in_ready after last"}, 64'(s_if.in_ready), 64'd0);
            wait_done(tag, runs[r].e_sq);
            check_results(tag, runs[r].e_sum, runs[r].e_abs, runs[r].e_sq, runs[r].e_max, runs[r].e_cnt);
        end

        // Zero-length run, then samples offered in DONE must be ignored.
        do_start("zero", 16'd0);
        for (int i = 0; i < 3; i++) begin
            s_if.in_valid    = 1'b1;
            s_if.op_a        = 8'd255;
            s_if.op_b        = 8'd255;
            s_if.approx_prod = 16'd0;
            @(negedge clk);
            s_if.in_valid = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("zero done",     64'(done),          64'd1);
        check("zero in_ready", 64'(s_if.in_ready), 64'd0);
        check_results("zero hold", 48'd0, 48'd0, 48'd0, 16'd0, 16'd0);

        // Gapped input with a start pulse while running.
        do_start("tog", 16'd4);
        for (int i = 0; i < 4; i++) begin
            s_if.in_valid    = 1'b1;
            s_if.op_a        = tog_a[i];
            s_if.op_b        = tog_b[i];
            s_if.approx_prod = tog_p[i];
            if (i == 2) begin
                start       = 1'b1;
                num_samples = 16'd7;
            end
            check($sformatf("tog in_ready before accept %0d", i), 64'(s_if.in_ready), 64'd1);
            @(negedge clk);
            start            = 1'b0;
            s_if.in_valid    = 1'b0;
            s_if.op_a        = 8'd255;
            s_if.op_b        = 8'd255;
            s_if.approx_prod = 16'd0;
            if (i < 3) @(negedge clk);
        end
        check("tog in_ready after 4th", 64'(s_if.in_ready), 64'd0);
        wait_done("tog", 48'd120);
        check_results("tog", -48'sd4, 48'd16, 48'd120, 16'd10, 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_mul_err_acc.md
Name: approx_mul_err_acc

Overview:
- Streaming error-metric accumulator that sits directly downstream of the 8x8 approximate Dadda multiplier.
- Consumes operand pairs and the multiplier's 16-bit approximate product, and recomputes the exact product internally.
- Accumulates signed error sum, absolute error sum, squared error sum (for MSE), maximum absolute error and error count over a programmed number of samples.
- Used for on-chip characterisation of power/MSE trade-offs.

Parameters:
- OP_W, 8, operand width; product width is 2*OP_W.
- CNT_W, 16, sample counter width; max run length 2^CNT_W-1.
- ACC_W, 48, width of the squared- and absolute-error accumulators.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- num_samples  in  CNT_W  run length, sampled on accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  accumulator can accept a sample.
- op_a  in  OP_W  multiplicand fed to the multiplier.
- op_b  in  OP_W  multiplier operand.
- approx_prod  in  2*OP_W  approximate product, combinationally aligned with op_a/op_b.
- sum_err  out  ACC_W  signed two's-complement sum of (approx - exact).
- sum_abs_err  out  ACC_W  sum of |approx - exact|.
- sum_sq_err  out  ACC_W  sum of (approx - exact)^2.
- max_abs_err  out  2*OP_W  largest |error| seen in the run.
- err_count  out  CNT_W  number of samples with nonzero error.
- done  out  1  high while results are final.

Behaviour:
- Reset: FSM to IDLE; all outputs 0 (in_ready=0, done=0, all accumulators, max and count 0). Reset mid-run aborts the run with no partial results retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Start handling: start in IDLE or DONE clears all accumulators, max and count, and latches num_samples into remaining.
  - If num_samples==0, go to DONE the next cycle with zeroed results.
  - Otherwise go to RUN.
  - start in RUN or DRAIN is ignored.
- RUN: in_ready=1. A sample is accepted when in_valid & in_ready; each acceptance decrements remaining. The acceptance that takes remaining to 0 moves the FSM to DRAIN in the same edge. in_ready drops the cycle after the last accept.
- DRAIN: in_ready=0. Wait until the pipeline is empty (all valid bits 0), then go to DONE.
- DONE: done=1; outputs hold stable until the next accepted start, at which point done falls in the same edge.
- Pipeline, 3 stages, each with its own valid bit:
  - S1 registers exact = op_a*op_b (2*OP_W) and err = {0,approx_prod} - {0,exact} as a (2*OP_W+1)-bit signed value.
  - S2 registers err, abs = |err| (2*OP_W bits, max 2^(2*OP_W)-1), sq = abs*abs (4*OP_W bits) and nz = (err!=0).
  - S3 updates the accumulators:
    - sum_err += sign-extended err.
    - sum_abs_err += abs.
    - sum_sq_err += sq.
    - max_abs_err = max(max_abs_err, abs).
    - err_count += nz.
- Latency: a sample accepted at edge t affects the outputs at edge t+3. done asserts at edge t_last+4 at the earliest.
- Overflow: accumulators wrap modulo 2^ACC_W; err_count cannot overflow because num_samples < 2^CNT_W. With defaults no wrap is possible, since 2^16 * 2^32 < 2^48.
- Output timing: outputs update live during RUN/DRAIN and are valid only when done=1.
- in_valid outside RUN is ignored; no sample is lost or double-counted under back-to-back valid.

Decomposition:
- Shared package approx_mul_pkg holds:
  - OP_W, CNT_W, ACC_W defaults.
  - A state enum for IDLE/RUN/DRAIN/DONE.
  - A struct for the S2 payload (err, abs, sq, nz).
- One natural sub-module, approx_err_pipe: S1-S2 arithmetic plus valid shift, with no FSM. The top level holds the FSM, counter and S3 accumulators.

Test Plan:
- Reset during RUN after 2 of 5 samples -> all outputs 0, in_ready=0 and done=0 immediately; the FSM stays in IDLE until start.
- start, num_samples=3; samples (3,5,15), (255,255,65024), (0,7,0) -> sum_err=-1, sum_abs_err=1, sum_sq_err=1, max_abs_err=1, err_count=1, done=1 four cycles after the last accept.
- start, num_samples=2; samples (16,16,260), (10,10,90) -> sum_err=-6, sum_abs_err=14, sum_sq_err=116, max_abs_err=10, err_count=2.
- start, num_samples=0 -> done=1 the next cycle with all results 0; in_valid pulses during DONE are ignored and the results are unchanged.
- num_samples=4 with in_valid toggling every other cycle and a start pulse mid-RUN -> exactly 4 samples accumulated, the mid-RUN start is ignored, and in_ready falls the cycle after the 4th accept.
- After DONE, start with num_samples=1 and sample (1,1,3) -> accumulators cleared then sum_err=2 and sum_sq_err=4; done low during the run.
